// File: rtl/buck_gate_ctrl.sv
// Dead-time-protected buck gate controller with diode emulation and
// cycle-by-cycle overcurrent protection, driven from the plant current sample.
module buck_gate_ctrl #(
   parameter int CNT_W = 16,
   parameter int DT_W  = 8,
   parameter int I_W   = 18
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic [CNT_W-1:0]      period,
   input  logic [CNT_W-1:0]      duty,
   input  logic [DT_W-1:0]       dead_time,
   input  logic signed [I_W-1:0] i_ind,
   input  logic signed [I_W-1:0] ls_thresh,
   input  logic signed [I_W-1:0] ocp_thresh,
   output logic                  hs,
   output logic                  ls,
   output logic                  ls_en,
   output logic                  cycle_start,
   output logic                  ocp_trip
);

   typedef enum logic [2:0] {IDLE, DT_RISE, HS_ON, DT_FALL, LS_ON, DIODE} state_t;

   state_t           state_q, state_d;
   state_t           low_st, start_st;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_nxt;
   logic [CNT_W-1:0] p_q, p_d, d_q, d_d;
   logic [CNT_W-1:0] p_in, d_in, t_ext;
   logic [DT_W-1:0]  t_q, t_d, dtc_q, dtc_d;
   logic             trip_q, trip_d;
   logic             ocp_q, ls_en_q;
   logic             hs_q, ls_q, cs_q;

   always_comb begin
      p_in     = (period < CNT_W'(2)) ? CNT_W'(2) : period;
      d_in     = (duty > p_in) ? p_in : duty;
      cnt_nxt  = cnt_q + CNT_W'(1);
      t_ext    = CNT_W'(t_q);
      low_st   = ls_en_q ? LS_ON : DIODE;
      // Start-of-period state is derived from the values being loaded now.
      if (dead_time != '0)
         start_st = DT_RISE;
      else if (d_in != '0)
         start_st = HS_ON;
      else
         start_st = low_st;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_nxt;
      p_d     = p_q;
      d_d     = d_q;
      t_d     = t_q;
      dtc_d   = dtc_q;
      trip_d  = trip_q;
      if (!en) begin
         state_d = IDLE;
         cnt_d   = '0;
         dtc_d   = '0;
         trip_d  = 1'b0;
      end else if (state_q == IDLE || cnt_q == p_q - CNT_W'(1)) begin
         // Wrap (or start-up) overrides every other transition.
         state_d = start_st;
         cnt_d   = '0;
         p_d     = p_in;
         d_d     = d_in;
         t_d     = dead_time;
         dtc_d   = '0;
         trip_d  = 1'b0;
      end else begin
         case (state_q)
            DT_RISE: begin
               if (cnt_nxt == t_ext) begin
                  state_d = (d_q > t_ext) ? HS_ON : DT_FALL;
                  dtc_d   = DT_W'(1);
               end
            end
            HS_ON: begin
               if (ocp_q || cnt_nxt == d_q) begin
                  if (ocp_q)
                     trip_d = 1'b1;
                  if (t_q != '0) begin
                     state_d = DT_FALL;
                     dtc_d   = DT_W'(1);
                  end else begin
                     state_d = low_st;
                  end
               end
            end
            DT_FALL: begin
               if (dtc_q >= t_q)
                  state_d = low_st;
               else
                  dtc_d = dtc_q + DT_W'(1);
            end
            LS_ON: begin
               if (!ls_en_q)
                  state_d = DIODE;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         p_q     <= CNT_W'(2);
         d_q     <= '0;
         t_q     <= '0;
         dtc_q   <= '0;
         trip_q  <= 1'b0;
         ocp_q   <= 1'b0;
         ls_en_q <= 1'b0;
         hs_q    <= 1'b0;
         ls_q    <= 1'b0;
         cs_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         p_q     <= p_d;
         d_q     <= d_d;
         t_q     <= t_d;
         dtc_q   <= dtc_d;
         trip_q  <= trip_d;
         ocp_q   <= (i_ind >= ocp_thresh);
         ls_en_q <= (i_ind > ls_thresh);
         hs_q    <= (state_d == HS_ON);
         ls_q    <= (state_d == LS_ON);
         cs_q    <= (state_d != IDLE) && (cnt_d == '0);
      end
   end

   assign hs          = hs_q;
   assign ls          = ls_q;
   assign ls_en       = ls_en_q;
   assign cycle_start = cs_q;
   assign ocp_trip    = trip_q;

endmodule

// File: tb/tb_buck_gate_ctrl.sv
// Bench for buck_gate_ctrl: hand-derived period vectors, directed corner
// sequences, and randomized traffic against a timeline-based reference model.
module tb_buck_gate_ctrl;

   logic               clk = 1'b0;
   logic               rst, en;
   logic [15:0]        period, duty;
   logic [7:0]         dead_time;
   logic signed [17:0] i_ind, ls_thresh, ocp_thresh;
   logic               hs, ls, ls_en, cycle_start, ocp_trip;

   int tests = 0;
   int fails = 0;

   buck_gate_ctrl #(.CNT_W(16), .DT_W(8), .I_W(18)) dut (
      .clk(clk), .rst(rst), .en(en), .period(period), .duty(duty),
      .dead_time(dead_time), .i_ind(i_ind), .ls_thresh(ls_thresh),
      .ocp_thresh(ocp_thresh), .hs(hs), .ls(ls), .ls_en(ls_en),
      .cycle_start(cycle_start), .ocp_trip(ocp_trip)
   );

   always #5 clk = ~clk;

   always @(negedge clk)
      assert (!(hs && ls)) else begin
         $display("FAIL overlap: hs=%0b ls=%0b, required never both 1", hs, ls);
         fails++;
      end

   // Reference model: period timeline from the latched P/D/T plus event times.
   int m_run = 0, m_c = 0, m_P = 2, m_D = 0, m_T = 0, m_trip = -1;
   bit m_lsok, m_lsen, m_ocp, m_hs, m_ls, m_cs, m_tr;

   function automatic void model_step();
      bit old_lsen, old_ocp, prev_hs;
      int fall, lows;
      old_lsen = m_lsen;
      old_ocp  = m_ocp;
      prev_hs  = m_hs;
      m_lsen   = (i_ind > ls_thresh);
      m_ocp    = (i_ind >= ocp_thresh);
      if (rst) begin
         m_lsen = 0; m_ocp = 0; m_run = 0;
      end else if (!en) begin
         m_run = 0;
      end else if (m_run == 0 || m_c == m_P - 1) begin
         m_P    = (int'(period) < 2) ? 2 : int'(period);
         m_D    = (int'(duty) > m_P) ? m_P : int'(duty);
         m_T    = int'(dead_time);
         m_c    = 0;
         m_trip = -1;
         m_lsok = 1;
         m_run  = 1;
      end else begin
         m_c++;
         if (prev_hs && old_ocp && m_trip < 0)
            m_trip = m_c;
      end
      if (m_run != 0) begin
         fall = (m_trip >= 0) ? m_trip : ((m_D > m_T) ? m_D : m_T);
         lows = fall + m_T;
         m_hs = (m_c >= m_T) && (m_c < fall);
         if (m_c >= lows)
            m_lsok = m_lsok & old_lsen;
         m_ls = (m_c >= lows) && m_lsok;
         m_cs = (m_c == 0);
         m_tr = (m_trip >= 0) && (m_c >= m_trip);
      end else begin
         m_c = 0; m_hs = 0; m_ls = 0; m_cs = 0; m_tr = 0;
      end
   endfunction

   task automatic tick();
      logic [4:0] act, exp;
      @(posedge clk);
      model_step();
      #1;
      act = {hs, ls, ls_en, cycle_start, ocp_trip};
      exp = {m_hs, m_ls, m_lsen, m_cs, m_tr};
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL model c=%0d: {hs,ls,ls_en,cs,trip} got %b required %b", m_c, act, exp);
      end
   endtask

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d required %0d", name, act, exp);
      end
   endtask

   task automatic run_to(input int target);
      int n = 0;
      while (!(m_run != 0 && m_c == target) && n < 1000) begin
         tick();
         n++;
      end
      chk("run_to_bound", (n < 1000) ? 1 : 0, 1);
   endtask

   task automatic setup(input int p, input int d, input int t);
      en = 1'b0;
      tick();
      period = 16'(p); duty = 16'(d); dead_time = 8'(t);
      i_ind = 18'sd1000; ls_thresh = 18'sd10; ocp_thresh = 18'sd131071;
      en = 1'b1;
      tick();
   endtask

   typedef struct {
      int p, d, t, pe, hs_first, hs_n, ls_first, ls_n;
   } vec_t;
   vec_t vecs[8];

   initial begin
      int hf, hn, lf, ln, tmp;
      vecs[0] = '{200, 100, 5, 200,  5,  95, 105,  95};
      vecs[1] = '{200,   3, 5, 200, -1,   0,  10, 190};
      vecs[2] = '{200, 250, 5, 200,  5, 195,  -1,   0};
      vecs[3] = '{200, 100, 0, 200,  0, 100, 100, 100};
      vecs[4] = '{  1,   1, 0,   2,  0,   1,   1,   1};
      vecs[5] = '{ 10,   8, 3,  10,  3,   5,  -1,   0};
      vecs[6] = '{  0,   0, 1,   2, -1,   0,  -1,   0};
      vecs[7] = '{ 30,  10, 10, 30, -1,   0,  20,  10};

      rst = 1'b1; en = 1'b0; period = 16'd200; duty = 16'd100; dead_time = 8'd5;
      i_ind = 18'sd1000; ls_thresh = 18'sd10; ocp_thresh = 18'sd131071;
      repeat (3) tick();
      chk("reset_outputs", int'({hs, ls, ls_en, cycle_start, ocp_trip}), 0);
      rst = 1'b0;

      for (int v = 0; v < 8; v++) begin
         setup(vecs[v].p, vecs[v].d, vecs[v].t);
         repeat (vecs[v].pe - 1) tick();
         hf = -1; hn = 0; lf = -1; ln = 0;
         for (int c = 0; c < vecs[v].pe; c++) begin
            tick();
            if (hs) begin if (hf < 0) hf = c; hn++; end
            if (ls) begin if (lf < 0) lf = c; ln++; end
         end
         chk($sformatf("vec%0d_hs_first", v), hf, vecs[v].hs_first);
         chk($sformatf("vec%0d_hs_count", v), hn, vecs[v].hs_n);
         chk($sformatf("vec%0d_ls_first", v), lf, vecs[v].ls_first);
         chk($sformatf("vec%0d_ls_count", v), ln, vecs[v].ls_n);
      end

      // Diode emulation: low side released and stays released
      setup(200, 100, 5);
      run_to(150); i_ind = 18'sd0;
      tick(); chk("diode_lsen_151", int'(ls_en), 0); chk("diode_ls_151", int'(ls), 1);
      tick(); chk("diode_ls_152", int'(ls), 0);
      run_to(170); i_ind = 18'sd1000;
      run_to(199); chk("diode_sticky_199", int'(ls), 0); chk("diode_lsen_199", int'(ls_en), 1);
      run_to(105); chk("diode_next_ls_105", int'(ls), 1);

      // Overcurrent trip mid high-side
      setup(200, 100, 5);
      run_to(40); i_ind = 18'sd131071;
      tick(); chk("ocp_hs_41", int'(hs), 1);
      tick(); chk("ocp_hs_42", int'(hs), 0); chk("ocp_trip_42", int'(ocp_trip), 1);
      i_ind = 18'sd1000;
      run_to(46); chk("ocp_ls_46", int'(ls), 0);
      tick(); chk("ocp_ls_47", int'(ls), 1);
      run_to(199); chk("ocp_trip_199", int'(ocp_trip), 1);
      tick(); chk("ocp_trip_clear", int'(ocp_trip), 0);
      run_to(5); chk("ocp_next_hs_5", int'(hs), 1);
      run_to(100); chk("ocp_next_hs_100", int'(hs), 0);

      // Duty change mid-period takes effect next period
      setup(200, 100, 5);
      run_to(50); duty = 16'd60;
      run_to(99); chk("duty_hs_99", int'(hs), 1);
      tick(); chk("duty_hs_100", int'(hs), 0);
      run_to(59); chk("duty_next_hs_59", int'(hs), 1);
      tick(); chk("duty_next_hs_60", int'(hs), 0);

      // Reset mid LS_ON
      setup(200, 100, 5);
      run_to(120); chk("rst_ls_120", int'(ls), 1);
      rst = 1'b1;
      tick(); chk("rst_outputs", int'({hs, ls, ls_en, cycle_start, ocp_trip}), 0);
      rst = 1'b0;
      tick(); chk("rst_cycle_start", int'(cycle_start), 1);
      run_to(4); chk("rst_hs_4", int'(hs), 0);
      tick(); chk("rst_hs_5", int'(hs), 1);

      // Randomized traffic against the model
      ls_thresh = 18'(int'($urandom_range(0, 400)) - 200);
      ocp_thresh = 18'(int'($urandom_range(300, 2000)));
      for (int n = 0; n < 4000; n++) begin
         if ($urandom_range(0, 49) == 0) begin
            period = 16'($urandom_range(0, 40));
            duty = 16'($urandom_range(0, 45));
            dead_time = 8'($urandom_range(0, 8));
         end
         if ($urandom_range(0, 3) == 0) begin
            tmp = int'($urandom_range(0, 3000)) - 500;
            i_ind = 18'(tmp);
         end
         if ($urandom_range(0, 199) == 0) begin
            ls_thresh = 18'(int'($urandom_range(0, 400)) - 200);
            ocp_thresh = 18'(int'($urandom_range(300, 2000)));
         end
         en = ($urandom_range(0, 299) == 0) ? ~en : 1'b1;
         rst = ($urandom_range(0, 499) == 0);
         tick();
      end
      rst = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
